// File: rtl/adder_pkg.sv
// Shared definitions for the adder result stage: default widths, the
// per-result flag record that travels next to the sum, and the saturation
// pattern used when the optional SATURATE_EN build clamps overflowed sums.
package adder_pkg;

  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_CNT_W = 8;

  // Flag record stored alongside the sum. A full result record is
  // {sum, res_flags_t}, i.e. {sum, cout, ovf, zero, neg} from MSB to LSB.
  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } res_flags_t;

  localparam int FLAGS_W = $bits(res_flags_t);

  // Saturated values have the shape {top, {N-1{rest}}}, so only two bits
  // are needed to describe them independently of the datapath width.
  typedef struct packed {
    logic top;
    logic rest;
  } sat_pat_t;

  // A wrapped sum with MSB set came from a positive overflow and clamps to
  // 0111..1; a wrapped sum with MSB clear came from a negative overflow and
  // clamps to 1000..0.
  function automatic sat_pat_t sat_value(input logic msb);
    sat_pat_t pat;
    pat.top  = ~msb;
    pat.rest = msb;
    return pat;
  endfunction

endpackage

// File: rtl/result_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. A main register drives the
// output; a skid register absorbs one extra entry while the output is held.
// in_ready comes straight from the skid-valid flop, so the upstream carry
// path never sees out_ready combinationally.
module result_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic xfer;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  assign accept = in_valid & ~skid_valid_q;
  assign xfer   = main_valid_q & out_ready;

  // Next-state for both entries; FIFO order is kept by always refilling
  // main from skid before accepting new data.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (skid_valid_q) begin
      // Full: nothing can be accepted; drain skid into main on transfer.
      if (xfer) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (xfer) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, because the output data must read zero after reset.
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/adder_result_stage.sv
// Registered result stage behind the carry-select adder. Builds the result
// record (optionally saturating the sum), derives zero/negative flags from
// the stored value, buffers it in a 2-entry skid buffer and counts accepted
// overflowed results with a saturating counter.
// Optional feature macro: SATURATE_EN (clamp overflowed sums at capture).
module adder_result_stage
  import adder_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_sum,
  input  logic             in_cout,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  localparam int REC_W = N + FLAGS_W;

  logic [N-1:0]     cap_sum;
  res_flags_t       cap_flags;
  logic [REC_W-1:0] cap_rec;
  logic [REC_W-1:0] out_rec;
  res_flags_t       out_flags;

  logic             accept;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  assign accept = in_valid & in_ready;

  // Capture path: choose the stored sum, then derive flags from it so the
  // flags always describe exactly what will appear on out_sum.
  always_comb begin
    cap_sum = in_sum;
`ifdef SATURATE_EN
    if (in_ovf) begin
      cap_sum = {sat_value(in_sum[N-1]).top, {(N-1){sat_value(in_sum[N-1]).rest}}};
    end
`endif
    cap_flags.cout = in_cout;
    cap_flags.ovf  = in_ovf;
    cap_flags.zero = (cap_sum == '0);
    cap_flags.neg  = cap_sum[N-1];
    cap_rec        = {cap_sum, cap_flags};
  end

  result_skid_buf #(
    .W (REC_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (cap_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_rec)
  );

  // Unpack the registered record onto the output ports.
  always_comb begin
    out_flags = out_rec[FLAGS_W-1:0];
    out_sum   = out_rec[REC_W-1:FLAGS_W];
    out_cout  = out_flags.cout;
    out_ovf   = out_flags.ovf;
    out_zero  = out_flags.zero;
    out_neg   = out_flags.neg;
  end

  // Overflow counter next-state: clear has priority, then a saturating +1.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (clr_count) begin
      ovf_count_d = '0;
    end else if (accept && in_ovf && !(&ovf_count_q)) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage (N=32, CNT_W=2). A queue-based
// model tracks buffered results and the overflow count; a compare process
// checks the DUT against it every cycle, and the directed sequence adds
// literal expectations. Compile with +define+SATURATE_EN to cover that build.
module tb_adder_result_stage;

  localparam int N     = 32;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_sum;
  logic             in_cout;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;
  logic [CNT_W-1:0] ovf_count;
  logic             clr_count;

  always #5 clk = ~clk;

  adder_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .ovf_count (ovf_count),
    .clr_count (clr_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } rec_t;

  rec_t q[$];
  int   cnt_m   = 0;
  bit   started = 0;

  function automatic rec_t expect_rec(input logic [N-1:0] s, input logic c, input logic o);
    rec_t r;
    r.sum = s;
`ifdef SATURATE_EN
    if (o) r.sum = (s >= 32'h8000_0000) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    r.cout = c;
    r.ovf  = o;
    r.zero = (r.sum == 0);
    r.neg  = (r.sum >= 32'h8000_0000);
    return r;
  endfunction

  always @(posedge clk) begin : model
    bit acc, xf;
    started = 1;
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
    end else begin
      acc = in_valid && (q.size() < 2);
      xf  = (q.size() > 0) && out_ready;
      if (xf) void'(q.pop_front());
      if (acc) q.push_back(expect_rec(in_sum, in_cout, in_ovf));
      if (clr_count) cnt_m = 0;
      else if (acc && in_ovf && cnt_m < CNT_MAX) cnt_m = cnt_m + 1;
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (started) begin
      check("m_in_ready", in_ready, q.size() < 2);
      check("m_out_valid", out_valid, q.size() > 0);
      check("m_ovf_count", ovf_count, cnt_m);
      if (q.size() > 0) begin
        check("m_out_sum", out_sum, q[0].sum);
        check("m_out_cout", out_cout, q[0].cout);
        check("m_out_ovf", out_ovf, q[0].ovf);
        check("m_out_zero", out_zero, q[0].zero);
        check("m_out_neg", out_neg, q[0].neg);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [N-1:0] t1_vals [4];
  logic [N-1:0] exp_sat;

  initial begin
    t1_vals[0] = 32'h0000_0001;
    t1_vals[1] = 32'h1234_5678;
    t1_vals[2] = 32'hFFFF_FFFF;
    t1_vals[3] = 32'h0000_00A5;

    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; in_ovf = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0;
    repeat (2) cyc();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ovf_count", ovf_count, 2'd0);
    check("rst_out_sum", out_sum, 32'h0);
    rst_n = 1'b1;
    cyc();

    // 1: streaming, one result per cycle, latency 1
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sum = t1_vals[i];
      cyc();
      check("t1_sum", out_sum, t1_vals[i]);
      check("t1_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    cyc();
    check("t1_drained", out_valid, 1'b0);

    // 2: backpressure into the skid entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 32'hAAAA_0001;
    cyc();
    in_sum = 32'hBBBB_0002;
    cyc();
    check("t2_in_ready_low", in_ready, 1'b0);
    check("t2_hold_a", out_sum, 32'hAAAA_0001);
    in_valid = 1'b0;
    cyc();
    check("t2_still_a", out_sum, 32'hAAAA_0001);
    out_ready = 1'b1;
    cyc();
    check("t2_then_b", out_sum, 32'hBBBB_0002);
    check("t2_in_ready_high", in_ready, 1'b1);
    cyc();
    check("t2_empty", out_valid, 1'b0);

    // 3: flags
    in_valid = 1'b1; in_sum = 32'h0;
    cyc();
    check("t3_zero", out_zero, 1'b1);
    check("t3_zero_neg", out_neg, 1'b0);
    in_sum = 32'h8000_0001;
    cyc();
    check("t3_neg", out_neg, 1'b1);
    check("t3_neg_zero", out_zero, 1'b0);
    in_valid = 1'b0;
    cyc();

    // 4: saturation (or wrap-around in the default build)
`ifdef SATURATE_EN
    exp_sat = 32'h7FFF_FFFF;
`else
    exp_sat = 32'h8000_0000;
`endif
    in_valid = 1'b1; in_sum = 32'h8000_0000; in_ovf = 1'b1; in_cout = 1'b1;
    cyc();
    check("t4_sum", out_sum, exp_sat);
    check("t4_ovf", out_ovf, 1'b1);
    check("t4_cout", out_cout, 1'b1);
    check("t4_count", ovf_count, 2'd1);
    in_valid = 1'b0; in_ovf = 1'b0; in_cout = 1'b0;
    cyc();

    // 5: counter saturation and clear priority
    clr_count = 1'b1;
    cyc();
    clr_count = 1'b0;
    check("t5_cleared", ovf_count, 2'd0);
    in_valid = 1'b1; in_ovf = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sum = 32'h4000_0000 + i;
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("t5_saturated", ovf_count, 2'd3);
    in_valid = 1'b1; clr_count = 1'b1; in_sum = 32'h0000_1000;
    cyc();
    check("t5_clr_wins", ovf_count, 2'd0);
    in_valid = 1'b0; clr_count = 1'b0; in_ovf = 1'b0;
    cyc();

    // 6: reset with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1; in_ovf = 1'b1; in_sum = 32'h0000_0011;
    cyc();
    in_sum = 32'h0000_0022;
    cyc();
    check("t6_full", in_ready, 1'b0);
    check("t6_count_pre", ovf_count, 2'd2);
    rst_n = 1'b0;
    cyc();
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_ovf_count", ovf_count, 2'd0);
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_out_sum", out_sum, 32'h0);
    rst_n = 1'b1; in_valid = 1'b0; in_ovf = 1'b0; out_ready = 1'b1;
    cyc();
    check("t6_no_partial", out_valid, 1'b0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
